// File: rtl/game_round_sequencer.sv
// game_round_sequencer
// Game-flow controller for Duck Hunt. It runs the dog intro and launches the
// ducks of a round one at a time. After each duck it shows the dog reaction
// for a fixed time. It keeps the duck, hit and round counters and decides at
// the end of each round whether the game continues or is over.
//
// Every output is a register. The next-state process computes the next value
// of each output together with the next state, so an output changes on the
// same edge as the state it belongs to. For example, dog_enable is high
// exactly while the state register holds INTRO.
//
// Handshake: there are no valid/ready pairs. Each input pulse is sampled on a
// rising edge and is only acted on in the state that consumes it. The same
// pulse arriving in any other state is dropped without side effects.
module game_round_sequencer #(
   parameter int DUCKS_PER_ROUND = 10,
   parameter int MIN_HITS        = 6,
   parameter int REACT_CYCLES    = 65_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       game_start,
   input  logic       dog_intro_done,
   input  logic       duck_hit,
   input  logic       duck_escaped,
   output logic       dog_enable,
   output logic       duck_launch,
   output logic [1:0] dog_react,
   output logic [3:0] duck_num,
   output logic [3:0] hits,
   output logic [7:0] round_num,
   output logic       round_over,
   output logic       game_over,
   output logic [2:0] state_dbg
);

   // One extra bit over $clog2 keeps the count comfortably in range
   // (27 bits for the default reaction length).
   localparam int TW = $clog2(REACT_CYCLES) + 1;

   localparam logic [TW-1:0] REACT_LAST = TW'(REACT_CYCLES - 1);
   localparam logic [3:0]    LAST_DUCK  = 4'(DUCKS_PER_ROUND - 1);
   localparam logic [3:0]    MAX_HITS   = 4'(DUCKS_PER_ROUND);
   localparam logic [3:0]    PASS_HITS  = 4'(MIN_HITS);

   localparam logic [1:0] REACT_NONE  = 2'd0;
   localparam logic [1:0] REACT_HOLD  = 2'd1;
   localparam logic [1:0] REACT_LAUGH = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_INTRO     = 3'd1,
      ST_LAUNCH    = 3'd2,
      ST_FLIGHT    = 3'd3,
      ST_REACT     = 3'd4,
      ST_ROUND_END = 3'd5
   } state_t;

   state_t          state_q;
   state_t          state_d;
   logic [TW-1:0]   timer_q;
   logic [TW-1:0]   timer_d;

   logic            dog_enable_d;
   logic            duck_launch_d;
   logic [1:0]      dog_react_d;
   logic [3:0]      duck_num_d;
   logic [3:0]      hits_d;
   logic [7:0]      round_num_d;
   logic            round_over_d;
   logic            game_over_d;

   // State register; reset aborts whatever game is in progress.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Output, counter and reaction-timer registers; all clear on reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         timer_q     <= '0;
         dog_enable  <= 1'b0;
         duck_launch <= 1'b0;
         dog_react   <= REACT_NONE;
         duck_num    <= 4'd0;
         hits        <= 4'd0;
         round_num   <= 8'd0;
         round_over  <= 1'b0;
         game_over   <= 1'b0;
      end else begin
         timer_q     <= timer_d;
         dog_enable  <= dog_enable_d;
         duck_launch <= duck_launch_d;
         dog_react   <= dog_react_d;
         duck_num    <= duck_num_d;
         hits        <= hits_d;
         round_num   <= round_num_d;
         round_over  <= round_over_d;
         game_over   <= game_over_d;
      end
   end

   // Next state and next register values. Pulses default low and counters
   // default to holding. Each input is looked at only in its own state.
   always_comb begin
      state_d       = state_q;
      timer_d       = timer_q;
      dog_enable_d  = 1'b0;
      duck_launch_d = 1'b0;
      dog_react_d   = dog_react;
      duck_num_d    = duck_num;
      hits_d        = hits;
      round_num_d   = round_num;
      round_over_d  = 1'b0;
      game_over_d   = game_over;

      case (state_q)
         ST_IDLE: begin
            dog_react_d = REACT_NONE;
            if (game_start) begin
               state_d      = ST_INTRO;
               dog_enable_d = 1'b1;
               round_num_d  = 8'd1;
               duck_num_d   = 4'd0;
               hits_d       = 4'd0;
               game_over_d  = 1'b0;
            end
         end

         ST_INTRO: begin
            dog_enable_d = 1'b1;
            if (dog_intro_done) begin
               state_d       = ST_LAUNCH;
               dog_enable_d  = 1'b0;
               duck_launch_d = 1'b1;
            end
         end

         ST_LAUNCH: begin
            // The launch pulse was registered on entry, so this state lasts one cycle.
            state_d = ST_FLIGHT;
         end

         ST_FLIGHT: begin
            // A hit reported in the same cycle as an escape counts as a hit.
            if (duck_hit) begin
               state_d     = ST_REACT;
               dog_react_d = REACT_HOLD;
               timer_d     = '0;
               if (hits < MAX_HITS) begin
                  hits_d = hits + 4'd1;
               end
            end else if (duck_escaped) begin
               state_d     = ST_REACT;
               dog_react_d = REACT_LAUGH;
               timer_d     = '0;
            end
         end

         ST_REACT: begin
            // The timer starts at 0 on entry. Leaving when it reaches
            // REACT_CYCLES-1 gives exactly REACT_CYCLES cycles of REACT.
            if (timer_q == REACT_LAST) begin
               dog_react_d = REACT_NONE;
               if (duck_num == LAST_DUCK) begin
                  state_d      = ST_ROUND_END;
                  round_over_d = 1'b1;
               end else begin
                  state_d       = ST_LAUNCH;
                  duck_launch_d = 1'b1;
                  duck_num_d    = duck_num + 4'd1;
               end
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end

         ST_ROUND_END: begin
            if (hits >= PASS_HITS) begin
               state_d      = ST_INTRO;
               dog_enable_d = 1'b1;
               duck_num_d   = 4'd0;
               hits_d       = 4'd0;
               if (round_num != 8'hFF) begin
                  round_num_d = round_num + 8'd1;
               end
            end else begin
               // Counters keep their values so the final score stays on screen.
               state_d     = ST_IDLE;
               game_over_d = 1'b1;
            end
         end

         default: begin
            state_d     = ST_IDLE;
            dog_react_d = REACT_NONE;
         end
      endcase
   end

   // Debug view of the state register.
   assign state_dbg = state_q;

endmodule

// File: tb/tb_game_round_sequencer.sv
// Directed testbench for game_round_sequencer with 3 ducks per round,
// 2 hits needed to pass and a 4-cycle reaction time.
module tb_game_round_sequencer;

   logic       clk;
   logic       rst;
   logic       game_start;
   logic       dog_intro_done;
   logic       duck_hit;
   logic       duck_escaped;
   logic       dog_enable;
   logic       duck_launch;
   logic [1:0] dog_react;
   logic [3:0] duck_num;
   logic [3:0] hits;
   logic [7:0] round_num;
   logic       round_over;
   logic       game_over;
   logic [2:0] state_dbg;

   int n_vec  = 0;
   int n_fail = 0;

   game_round_sequencer #(
      .DUCKS_PER_ROUND(3),
      .MIN_HITS       (2),
      .REACT_CYCLES   (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .game_start    (game_start),
      .dog_intro_done(dog_intro_done),
      .duck_hit      (duck_hit),
      .duck_escaped  (duck_escaped),
      .dog_enable    (dog_enable),
      .duck_launch   (duck_launch),
      .dog_react     (dog_react),
      .duck_num      (duck_num),
      .hits          (hits),
      .round_num     (round_num),
      .round_over    (round_over),
      .game_over     (game_over),
      .state_dbg     (state_dbg)
   );

   // Clock: 10 ns period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout, expected end of stimulus");
      $fatal(1, "watchdog expired");
   end

   // Advance one clock and sample 1 ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_dog_enable"},  dog_enable,  0);
      check({tag, "_duck_launch"}, duck_launch, 0);
      check({tag, "_dog_react"},   dog_react,   0);
      check({tag, "_duck_num"},    duck_num,    0);
      check({tag, "_hits"},        hits,        0);
      check({tag, "_round_num"},   round_num,   0);
      check({tag, "_round_over"},  round_over,  0);
      check({tag, "_game_over"},   game_over,   0);
      check({tag, "_state"},       state_dbg,   0);
   endtask

   // Call from FLIGHT. Applies one result and checks the 4-cycle reaction
   // (with a stray hit inside it), then checks the launch of the next duck
   // or the round_over pulse.
   task automatic duck(input logic hit, input logic esc, input logic last,
                       input logic [1:0] exp_react, input logic [3:0] exp_hits,
                       input logic [3:0] exp_num);
      duck_hit     = hit;
      duck_escaped = esc;
      tick();
      duck_hit     = 1'b0;
      duck_escaped = 1'b0;
      check("react_on",    dog_react, exp_react);
      check("react_hits",  hits,      exp_hits);
      check("react_state", state_dbg, 4);
      for (int k = 1; k < 4; k++) begin
         duck_hit = (k == 2);
         tick();
         duck_hit = 1'b0;
         check("react_hold",      dog_react, exp_react);
         check("react_hold_hits", hits,      exp_hits);
      end
      tick();
      check("react_off", dog_react, 0);
      if (!last) begin
         check("next_launch",       duck_launch, 1);
         check("next_launch_state", state_dbg,   2);
         check("next_duck_num",     duck_num,    exp_num + 4'd1);
         tick();
         check("launch_end",  duck_launch, 0);
         check("flight_state", state_dbg,  3);
      end else begin
         check("round_over_on",  round_over, 1);
         check("round_end_state", state_dbg, 5);
         check("last_duck_num",  duck_num,   exp_num);
         tick();
         check("round_over_off", round_over, 0);
      end
   endtask

   // Call from INTRO: ends the intro and checks the single launch pulse.
   task automatic intro_to_flight();
      dog_intro_done = 1'b1;
      tick();
      dog_intro_done = 1'b0;
      check("launch_pulse", duck_launch, 1);
      check("intro_off",    dog_enable,  0);
      check("launch_state", state_dbg,   2);
      tick();
      check("launch_single", duck_launch, 0);
      check("flight_state",  state_dbg,   3);
   endtask

   initial begin
      rst            = 1'b0;
      game_start     = 1'b0;
      dog_intro_done = 1'b0;
      duck_hit       = 1'b0;
      duck_escaped   = 1'b0;
      tick();
      tick();
      check_all_zero("reset");
      rst = 1'b1;
      tick();
      check("idle_after_reset", state_dbg, 0);

      // Test 1: start, intro, and a stray hit during INTRO.
      game_start = 1'b1;
      tick();
      game_start = 1'b0;
      check("start_dog_enable", dog_enable, 1);
      check("start_round",      round_num,  1);
      check("start_state",      state_dbg,  1);
      duck_hit = 1'b1;
      tick();
      duck_hit = 1'b0;
      check("intro_stray_hits",  hits,       0);
      check("intro_stray_state", state_dbg,  1);
      check("intro_hold_enable", dog_enable, 1);
      intro_to_flight();

      // Test 2: three hits, round passes.
      duck(1'b1, 1'b0, 1'b0, 2'd1, 4'd1, 4'd0);
      duck(1'b1, 1'b0, 1'b0, 2'd1, 4'd2, 4'd1);
      duck(1'b1, 1'b0, 1'b1, 2'd1, 4'd3, 4'd2);
      check("pass_state",     state_dbg,  1);
      check("pass_enable",    dog_enable, 1);
      check("pass_round",     round_num,  2);
      check("pass_hits",      hits,       0);
      check("pass_duck_num",  duck_num,   0);
      check("pass_game_over", game_over,  0);

      // Round 2: stray game_start during FLIGHT.
      intro_to_flight();
      game_start = 1'b1;
      tick();
      game_start = 1'b0;
      check("flight_stray_state", state_dbg, 3);
      check("flight_stray_round", round_num, 2);
      check("flight_stray_en",    dog_enable, 0);

      // Tests 4 and 3: hit+escape together, then two escapes; round fails.
      duck(1'b1, 1'b1, 1'b0, 2'd1, 4'd1, 4'd0);
      duck(1'b0, 1'b1, 1'b0, 2'd2, 4'd1, 4'd1);
      duck(1'b0, 1'b1, 1'b1, 2'd2, 4'd1, 4'd2);
      check("fail_state",     state_dbg,  0);
      check("fail_game_over", game_over,  1);
      check("fail_hits_held", hits,       1);
      check("fail_round",     round_num,  2);
      check("fail_duck_num",  duck_num,   2);
      check("fail_enable",    dog_enable, 0);

      // Stray escape in IDLE.
      duck_escaped = 1'b1;
      tick();
      duck_escaped = 1'b0;
      check("idle_stray_state", state_dbg, 0);
      check("idle_stray_hits",  hits,      1);
      check("idle_stray_react", dog_react, 0);
      check("idle_stray_over",  game_over, 1);

      // Test 6: new game, reset during REACT.
      game_start = 1'b1;
      tick();
      game_start = 1'b0;
      check("restart_game_over", game_over, 0);
      check("restart_round",     round_num, 1);
      check("restart_hits",      hits,      0);
      intro_to_flight();
      duck_hit = 1'b1;
      tick();
      duck_hit = 1'b0;
      check("pre_reset_react", dog_react, 1);
      rst = 1'b0;
      #1;
      check_all_zero("rst_react");
      tick();
      check_all_zero("rst_react_hold");
      rst = 1'b1;
      tick();
      check("rst_react_idle", state_dbg, 0);

      // Reset during INTRO.
      game_start = 1'b1;
      tick();
      game_start = 1'b0;
      check("pre_reset_intro", dog_enable, 1);
      rst = 1'b0;
      #1;
      check_all_zero("rst_intro");
      tick();
      rst = 1'b1;
      tick();

      // Normal sequence after reset.
      game_start = 1'b1;
      tick();
      game_start = 1'b0;
      check("post_rst_enable", dog_enable, 1);
      check("post_rst_round",  round_num,  1);
      intro_to_flight();
      duck(1'b0, 1'b1, 1'b0, 2'd2, 4'd0, 4'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
